// File: rtl/bp_pkg.sv
// Shared definitions between the fetch-stage 2-bit predictor and the execute-side
// branch resolve unit.
package bp_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int BP_XLEN     = 32;

    // Two-bit saturating predictor state encoding, shared with the fetch predictor.
    typedef enum logic [1:0] {
        BP_STRONG_NT = 2'b00,
        BP_WEAK_NT   = 2'b01,
        BP_WEAK_T    = 2'b10,
        BP_STRONG_T  = 2'b11
    } bp_state_e;

    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               taken;
        logic [BP_XLEN-1:0] target;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of in-flight branch predictions. A clear drops every entry and
// rewinds both pointers in one cycle.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 65,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Guard push/pop against overflow and underflow.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (push && (count_r < CNT_W'(DEPTH))) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (pop && (count_r != CNT_W'(0))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: compares the oldest in-flight prediction with the
// actual outcome, raises flush/redirect on mispredict and trains the predictor.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 32,
    parameter  int CNT_W = 32,
    localparam int QW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic [XLEN-1:0]  pred_pc,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [XLEN-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [QW-1:0]    q_count,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts,
    output logic             err_underflow
);

    localparam int EW = 2 * XLEN + 1;

    function automatic logic is_mispredict(
        input logic            p_taken,
        input logic [XLEN-1:0] p_target,
        input logic            a_taken,
        input logic [XLEN-1:0] a_target
    );
        return (p_taken != a_taken) || (p_taken && a_taken && (p_target != a_target));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [EW-1:0]    push_data_s;
    logic [EW-1:0]    head_data_s;
    logic [XLEN-1:0]  head_pc_s;
    logic             head_taken_s;
    logic [XLEN-1:0]  head_target_s;
    logic [QW-1:0]    fifo_count_s;
    logic             ready_s;
    logic             push_s;
    logic             resolve_s;
    logic             mispredict_s;
    logic             underflow_s;
    logic [XLEN-1:0]  redirect_next_s;

    logic             flush_r;
    logic [XLEN-1:0]  redirect_pc_r;
    logic             upd_valid_r;
    logic [XLEN-1:0]  upd_pc_r;
    logic             upd_taken_r;
    logic [CNT_W-1:0] branches_r;
    logic [CNT_W-1:0] mispredicts_r;
    logic             err_underflow_r;

    assign push_data_s   = {pred_pc, pred_taken, pred_target};
    assign head_pc_s     = head_data_s[EW-1 -: XLEN];
    assign head_taken_s  = head_data_s[XLEN];
    assign head_target_s = head_data_s[XLEN-1:0];

    bp_inflight_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mispredict_s),
        .push  (push_s),
        .pop   (resolve_s),
        .din   (push_data_s),
        .dout  (head_data_s),
        .count (fifo_count_s)
    );

    // Handshake, resolve qualification and mispredict detection. Pushes during a
    // flush cycle belong to the wrong path and are refused.
    always_comb begin
        ready_s         = (fifo_count_s < QW'(DEPTH)) && !flush_r;
        push_s          = pred_valid && ready_s;
        resolve_s       = 1'b0;
        underflow_s     = 1'b0;
        if (fifo_count_s != QW'(0)) begin
            resolve_s = res_valid;
        end else begin
            underflow_s = res_valid;
        end
        mispredict_s    = resolve_s &&
                          is_mispredict(head_taken_s, head_target_s, res_taken, res_target);
        redirect_next_s = res_taken ? res_target : head_pc_s + XLEN'(INSTR_BYTES);
    end

    // Registered flush/update pulses, redirect target, statistics and error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_r         <= 1'b0;
            redirect_pc_r   <= XLEN'(0);
            upd_valid_r     <= 1'b0;
            upd_pc_r        <= XLEN'(0);
            upd_taken_r     <= 1'b0;
            branches_r      <= CNT_W'(0);
            mispredicts_r   <= CNT_W'(0);
            err_underflow_r <= 1'b0;
        end else begin
            flush_r     <= mispredict_s;
            upd_valid_r <= resolve_s;
            if (resolve_s) begin
                upd_pc_r    <= head_pc_s;
                upd_taken_r <= res_taken;
                branches_r  <= sat_inc(branches_r);
            end
            if (mispredict_s) begin
                redirect_pc_r <= redirect_next_s;
                mispredicts_r <= sat_inc(mispredicts_r);
            end
            if (underflow_s) begin
                err_underflow_r <= 1'b1;
            end
        end
    end

    assign pred_ready       = ready_s;
    assign flush            = flush_r;
    assign redirect_pc      = redirect_pc_r;
    assign upd_valid        = upd_valid_r;
    assign upd_pc           = upd_pc_r;
    assign upd_taken        = upd_taken_r;
    assign q_count          = fifo_count_s;
    assign stat_branches    = branches_r;
    assign stat_mispredicts = mispredicts_r;
    assign err_underflow    = err_underflow_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven scoreboard bench for branch_resolve_unit (DEPTH=4, XLEN=32, CNT_W=4).
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [2:0]  q_count;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;
    logic        err_underflow;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .XLEN(32), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .q_count          (q_count),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
        .err_underflow    (err_underflow)
    );

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        pt;
        logic [31:0] ptg;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic        rdy;
        logic        f;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [2:0]  qc;
        logic [3:0]  br;
        logic [3:0]  mp;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        pred_valid  = 1'b0;
        pred_pc     = 32'h0;
        pred_taken  = 1'b0;
        pred_target = 32'h0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        res_target  = 32'h0;
    endtask

    task automatic drive(input vec_t v);
        pred_valid  = v.pv;
        pred_pc     = v.ppc;
        pred_taken  = v.pt;
        pred_target = v.ptg;
        res_valid   = v.rv;
        res_taken   = v.rt;
        res_target  = v.rtg;
    endtask

    initial begin
        vec_t e;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_upd_pc", upd_pc, 32'h0);
        check("rst_upd_taken", 32'(upd_taken), 32'd0);
        check("rst_redirect", redirect_pc, 32'h0);
        check("rst_q_count", 32'(q_count), 32'd0);
        check("rst_branches", 32'(stat_branches), 32'd0);
        check("rst_mispredicts", 32'(stat_mispredicts), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // pv ppc pt ptg | rv rt rtg | rdy | f rpc | uv upc ut | qc br mp err
        vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd1, 4'd0, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 32'h110, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd2, 4'd0, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 32'h120, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd3, 4'd0, 4'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 3'd2, 4'd1, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 32'h999, 1'b1, 32'h0,   1'b1, 1'b1, 32'h400, 1'b1, 1'b1, 32'h400, 1'b1, 32'h110, 1'b1, 3'd0, 4'd2, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 32'h120, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd0, 4'd2, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 32'h120, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd1, 4'd2, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h124, 1'b1, 32'h120, 1'b0, 3'd0, 4'd3, 4'd2, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd0, 4'd3, 4'd2, 1'b0});
        vecs.push_back('{1'b1, 32'h130, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd1, 4'd3, 4'd2, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h304, 1'b1, 1'b1, 32'h304, 1'b1, 32'h130, 1'b1, 3'd0, 4'd4, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd0, 4'd4, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd1, 4'd4, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 32'h210, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd2, 4'd4, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 32'h220, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd3, 4'd4, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 32'h230, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd4, 4'd4, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 32'h240, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd4, 4'd4, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 32'h250, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 3'd3, 4'd5, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 32'h260, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h210, 1'b0, 3'd3, 4'd6, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd3, 4'd6, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h220, 1'b0, 3'd2, 4'd7, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h230, 1'b0, 3'd1, 4'd8, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h260, 1'b0, 3'd0, 4'd9, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd0, 4'd9, 4'd3, 1'b1});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 3'd0, 4'd9, 4'd3, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d_ready", i), 32'(pred_ready), 32'(vecs[i].rdy));
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("row%0d_flush", i), 32'(flush), 32'(e.f));
            if (e.f) check($sformatf("row%0d_redirect", i), redirect_pc, e.rpc);
            check($sformatf("row%0d_upd_valid", i), 32'(upd_valid), 32'(e.uv));
            if (e.uv) begin
                check($sformatf("row%0d_upd_pc", i), upd_pc, e.upc);
                check($sformatf("row%0d_upd_taken", i), 32'(upd_taken), 32'(e.ut));
            end
            check($sformatf("row%0d_q_count", i), 32'(q_count), 32'(e.qc));
            check($sformatf("row%0d_branches", i), 32'(stat_branches), 32'(e.br));
            check($sformatf("row%0d_mispredicts", i), 32'(stat_mispredicts), 32'(e.mp));
            check($sformatf("row%0d_err", i), 32'(err_underflow), 32'(e.err));
        end

        // Reset mid-operation with two entries queued and a would-be mispredict.
        @(negedge clk);
        idle();
        pred_valid = 1'b1;
        pred_pc    = 32'h700;
        @(negedge clk);
        pred_pc    = 32'h710;
        @(posedge clk);
        #1;
        check("pre_rst_q_count", 32'(q_count), 32'd2);
        @(negedge clk);
        idle();
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        res_target = 32'h900;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_q_count", 32'(q_count), 32'd0);
        check("mid_rst_flush", 32'(flush), 32'd0);
        check("mid_rst_upd_valid", 32'(upd_valid), 32'd0);
        check("mid_rst_err", 32'(err_underflow), 32'd0);
        check("mid_rst_branches", 32'(stat_branches), 32'd0);
        check("mid_rst_mispredicts", 32'(stat_mispredicts), 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_flush", 32'(flush), 32'd0);

        // Saturation of the 4-bit branch counter: 16 correct resolves.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle();
            pred_valid = 1'b1;
            pred_pc    = 32'h800 + 32'(i * 16);
            @(negedge clk);
            idle();
            res_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("sat_branches%0d", i), 32'(stat_branches), (i < 15) ? 32'(i + 1) : 32'd15);
        end
        check("sat_upd_valid", 32'(upd_valid), 32'd1);
        check("sat_upd_pc", upd_pc, 32'h8f0);
        check("sat_mispredicts", 32'(stat_mispredicts), 32'd0);
        check("sat_q_count", 32'(q_count), 32'd0);
        @(negedge clk);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
